spi_ram_arbiter: RTL and testbench

SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

---
 rtl/spi_ram_arb_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 27 ++
 rtl/spi_ram_arbiter.sv | 156 +++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_arb_pkg.sv
// Shared constants and types for spi_ram_arbiter: SPI command codes,
// arbiter FSM states and the one-entry SPI pending-slot layout.
package spi_ram_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPI_ACC = 2'd1,
    LP_ACC  = 2'd2,
    RD_RESP = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spi_slot_t;

  // Data commands (01/11) need a RAM access; address loads (00/10) do not.
  function automatic logic is_data_cmd(input logic [1:0] cmd);
    return (cmd == CMD_WR_DATA) || (cmd == CMD_RD_DATA);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin selector; requester A wins the first tie
// because the last-grant bit comes out of reset pointing at B.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_advance,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  logic r_last_b;

  assign o_gnt_a = i_req_a & (~i_req_b | r_last_b);
  assign o_gnt_b = i_req_b & ~o_gnt_a;

  // NOTE: reset is synchronous here, so rst_n is tested inside the clocked block only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
    end else if (i_advance && (o_gnt_a || o_gnt_b)) begin
      r_last_b <= o_gnt_b;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Arbitrates a single-port RAM between an SPI command stream and a local port.
// Define SPI_ARB_AUTOINC_EN to post-increment the address after each data command.
module spi_ram_arbiter
  import spi_ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              lp_req,
  input  logic              lp_we,
  input  logic [ADDR_W-1:0] lp_addr,
  input  logic [DATA_W-1:0] lp_wdata,
  output logic              lp_gnt,
  output logic              lp_rvalid,
  output logic [DATA_W-1:0] lp_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              spi_overrun
);

  arb_state_e        r_state;
  spi_slot_t         r_slot;
  logic              r_slot_vld;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_overrun;
  logic              r_src_spi;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic [DATA_W-1:0] r_lp_rdata;
  logic              r_lp_rvalid;

  logic [1:0]        w_cmd;
  logic              w_data_word;
  logic              w_free;
  logic              w_capture;
  logic              w_drop;
  logic [ADDR_W-1:0] w_cap_addr;
  logic              w_gnt_spi;
  logic              w_gnt_lp;

  assign w_cmd       = rx_data[9:8];
  assign w_data_word = rx_valid && is_data_cmd(w_cmd);
  // The slot drains at the end of SPI_ACC, so a word arriving then still fits.
  assign w_free      = (r_state == SPI_ACC);
  assign w_capture   = w_data_word && (!r_slot_vld || w_free);
  assign w_drop      = w_data_word && r_slot_vld && !w_free;
  assign w_cap_addr  = (w_cmd == CMD_WR_DATA) ? r_wr_addr : r_rd_addr;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req_a   (r_slot_vld),
    .i_req_b   (lp_req),
    .i_advance (r_state == IDLE),
    .o_gnt_a   (w_gnt_spi),
    .o_gnt_b   (w_gnt_lp)
  );

  // NOTE: every register below is assigned with <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_slot      <= '0;
      r_slot_vld  <= 1'b0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_overrun   <= 1'b0;
      r_src_spi   <= 1'b0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_lp_rdata  <= '0;
      r_lp_rvalid <= 1'b0;
    end else begin
      r_tx_valid  <= 1'b0;
      r_lp_rvalid <= 1'b0;

      if (rx_valid && (w_cmd == CMD_WR_ADDR)) r_wr_addr <= rx_data[7:0];
      if (rx_valid && (w_cmd == CMD_RD_ADDR)) r_rd_addr <= rx_data[7:0];
`ifdef SPI_ARB_AUTOINC_EN
      if (w_capture && (w_cmd == CMD_WR_DATA)) r_wr_addr <= r_wr_addr + 8'd1;
      if (w_capture && (w_cmd == CMD_RD_DATA)) r_rd_addr <= r_rd_addr + 8'd1;
`endif

      if (w_free) r_slot_vld <= 1'b0;
      if (w_capture) begin
        r_slot_vld <= 1'b1;
        r_slot     <= {w_cmd == CMD_WR_DATA, w_cap_addr, rx_data[7:0]};
      end
      if (w_drop) r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_gnt_spi) begin
            r_state   <= SPI_ACC;
            r_src_spi <= 1'b1;
          end else if (w_gnt_lp) begin
            r_state   <= LP_ACC;
            r_src_spi <= 1'b0;
          end
        end
        SPI_ACC: r_state <= r_slot.we ? IDLE : RD_RESP;
        LP_ACC:  r_state <= lp_we ? IDLE : RD_RESP;
        RD_RESP: begin
          if (r_src_spi) begin
            r_tx_data  <= ram_rdata;
            r_tx_valid <= 1'b1;
          end else begin
            r_lp_rdata  <= ram_rdata;
            r_lp_rvalid <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    lp_gnt    = 1'b0;
    case (r_state)
      SPI_ACC: begin
        ram_en    = 1'b1;
        ram_we    = r_slot.we;
        ram_addr  = r_slot.addr;
        ram_wdata = r_slot.data;
      end
      LP_ACC: begin
        ram_en    = 1'b1;
        ram_we    = lp_we;
        ram_addr  = lp_addr;
        ram_wdata = lp_wdata;
        lp_gnt    = 1'b1;
      end
      default: ;
    endcase
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign lp_rdata    = r_lp_rdata;
  assign lp_rvalid   = r_lp_rvalid;
  assign spi_overrun = r_overrun;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed and randomized bench for spi_ram_arbiter with a RAM model and a
// transaction-level reference (memory image, address registers, last grant).
module tb_spi_ram_arbiter;

`ifdef SPI_ARB_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       lp_req, lp_we;
  logic [7:0] lp_addr, lp_wdata;
  logic       lp_gnt, lp_rvalid;
  logic [7:0] lp_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       spi_overrun;

  spi_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .lp_req(lp_req), .lp_we(lp_we),
    .lp_addr(lp_addr), .lp_wdata(lp_wdata), .lp_gnt(lp_gnt),
    .lp_rvalid(lp_rvalid), .lp_rdata(lp_rdata), .ram_en(ram_en),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .spi_overrun(spi_overrun)
  );

  always #5 clk = ~clk;

  // External single-port RAM: read data appears the cycle after the read strobe.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  // Reference state.
  logic [7:0] exp_mem [256];
  logic [7:0] m_wr, m_rd;
  bit         m_last_spi;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic mid(); #4; endtask
  task automatic idle(input int n); repeat (n) cyc(); endtask

  function automatic logic [63:0] all_outs();
    return {tx_data, tx_valid, lp_gnt, lp_rvalid, lp_rdata, ram_en, ram_we,
            ram_addr, ram_wdata, spi_overrun};
  endfunction

  // Applies one accepted SPI word to the reference; returns the address a data command targets.
  function automatic logic [7:0] model_spi(input logic [9:0] w);
    logic [7:0] a;
    a = 8'h00;
    case (w[9:8])
      2'b00: m_wr = w[7:0];
      2'b10: m_rd = w[7:0];
      2'b01: begin a = m_wr; exp_mem[a] = w[7:0]; if (AUTOINC) m_wr = m_wr + 8'd1; end
      default: begin a = m_rd; if (AUTOINC) m_rd = m_rd + 8'd1; end
    endcase
    return a;
  endfunction

  task automatic spi_word(input logic [9:0] w);
    rx_data = w; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; lp_req = 1'b0; rx_valid = 1'b0;
    cyc(); cyc(); mid();
    check({tag, "_outs_zero"}, all_outs(), 64'd0);
    cyc();
    rst_n = 1'b1;
    m_wr = 8'h00; m_rd = 8'h00; m_last_spi = 1'b0;
  endtask

  // Called at the start of the cycle after the triggering word; waits for a RAM access.
  task automatic expect_access(input string tag, input logic we, input logic [7:0] a,
                               input logic [7:0] d, output int lat);
    int k;
    bit found;
    k = 1; found = 1'b0; lat = 0;
    while (!found && k <= 8) begin
      mid();
      if (ram_en) found = 1'b1;
      else begin cyc(); k++; end
    end
    check({tag, "_seen"}, found, 1);
    if (found) begin
      check({tag, "_we"}, ram_we, we);
      check({tag, "_addr"}, ram_addr, a);
      if (we) check({tag, "_wdata"}, ram_wdata, d);
      lat = k;
    end
    cyc();
  endtask

  task automatic wait_tx(input string tag, output int lat, output logic [7:0] d);
    bit found;
    found = 1'b0; lat = 1; d = 8'h00;
    while (!found && lat <= 8) begin
      mid();
      if (tx_valid) begin found = 1'b1; d = tx_data; end
      else begin cyc(); lat++; end
    end
    check({tag, "_tx_seen"}, found, 1);
    cyc();
  endtask

  task automatic lp_access(input string tag, input logic we, input logic [7:0] a, input logic [7:0] d);
    bit found;
    int k;
    lp_req = 1'b1; lp_we = we; lp_addr = a; lp_wdata = d;
    found = 1'b0; k = 0;
    while (!found && k < 8) begin
      mid();
      if (lp_gnt) found = 1'b1; else begin cyc(); k++; end
    end
    check({tag, "_gnt"}, found, 1);
    check({tag, "_ram"}, {ram_en, ram_we, ram_addr}, {1'b1, we, a});
    if (we) begin check({tag, "_wdata"}, ram_wdata, d); exp_mem[a] = d; end
    cyc();
    lp_req = 1'b0;
    if (!we) begin
      found = 1'b0; k = 0;
      while (!found && k < 6) begin
        mid();
        if (lp_rvalid) found = 1'b1; else begin cyc(); k++; end
      end
      check({tag, "_rvalid"}, found, 1);
      check({tag, "_rdata"}, lp_rdata, exp_mem[a]);
      cyc();
    end
    m_last_spi = 1'b0;
  endtask

  // SPI write and LP read become pending in the same IDLE cycle.
  task automatic contend(input string tag, input logic [7:0] la, input logic [7:0] sa, input logic [7:0] sd);
    int   order[$];
    bit   exp_lp_first, got_rv, drop;
    logic [7:0] rv, exp_rd;
    exp_lp_first = m_last_spi;
    spi_word({2'b00, sa}); void'(model_spi({2'b00, sa}));
    exp_rd = exp_mem[la];
    rx_data = {2'b01, sd}; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0; void'(model_spi({2'b01, sd}));
    lp_req = 1'b1; lp_we = 1'b0; lp_addr = la; lp_wdata = 8'h00;
    got_rv = 1'b0; rv = 8'h00;
    for (int k = 0; k < 14; k++) begin
      mid();
      drop = lp_gnt;
      if (ram_en) order.push_back(lp_gnt ? 1 : 0);
      if (lp_rvalid) begin got_rv = 1'b1; rv = lp_rdata; end
      cyc();
      if (drop) lp_req = 1'b0;
    end
    check({tag, "_n_access"}, order.size(), 2);
    check({tag, "_first"}, order[0], exp_lp_first);
    check({tag, "_second"}, order[1], !exp_lp_first);
    check({tag, "_rvalid"}, got_rv, 1);
    check({tag, "_rdata"}, rv, exp_rd);
    m_last_spi = exp_lp_first;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int         lat, cnt;
    logic [7:0] a, d, ea, got;
    bit         any;

    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'($urandom);
      exp_mem[i] = ram[i];
    end
    rx_data = '0; rx_valid = 1'b0; lp_req = 1'b0; lp_we = 1'b0;
    lp_addr = '0; lp_wdata = '0; rst_n = 1'b0;
    do_reset("reset");

    // Load wr_addr then write: access two cycles after the data word.
    spi_word(10'h005); void'(model_spi(10'h005));
    spi_word(10'h1A5); void'(model_spi(10'h1A5));
    expect_access("spi_wr", 1'b1, 8'h05, 8'hA5, lat);
    check("spi_wr_latency", lat, 2);
    m_last_spi = 1'b1;
    idle(2);

    // Read back: tx_valid four cycles after the read word.
    spi_word(10'h205); void'(model_spi(10'h205));
    spi_word(10'h300); void'(model_spi(10'h300));
    wait_tx("spi_rd", lat, got);
    check("spi_rd_latency", lat, 4);
    check("spi_rd_data", got, 8'hA5);
    idle(2);

    do_reset("reset2");
    contend("contend_a", 8'h10, 8'h44, 8'($urandom));
    idle(2);
    spi_word(10'h060); void'(model_spi(10'h060));
    spi_word(10'h17E); ea = model_spi(10'h17E);
    expect_access("spi_only", 1'b1, ea, 8'h7E, lat);
    m_last_spi = 1'b1;
    idle(2);
    contend("contend_b", 8'h61, 8'h62, 8'($urandom));
    idle(2);

    // Word arriving in SPI_ACC is accepted without overrun.
    spi_word(10'h080); void'(model_spi(10'h080));
    spi_word(10'h1C1); ea = model_spi(10'h1C1);
    mid();
    check("free_idle_gap", ram_en, 0);
    cyc();
    rx_data = 10'h1C2; rx_valid = 1'b1;
    mid();
    check("free_acc1", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, ea, 8'hC1});
    cyc();
    rx_valid = 1'b0; ea = model_spi(10'h1C2);
    expect_access("free_acc2", 1'b1, ea, 8'hC2, lat);
    check("free_no_overrun", spi_overrun, 0);
    m_last_spi = 1'b1;
    idle(2);

    // Back-to-back data words with the slot full: second is dropped.
    spi_word(10'h020); void'(model_spi(10'h020));
    rx_data = 10'h111; rx_valid = 1'b1;
    cyc();
    ea = model_spi(10'h111);
    rx_data = 10'h122;
    cyc();
    rx_valid = 1'b0;
    mid();
    check("ovr_access", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, ea, 8'h11});
    check("ovr_flag", spi_overrun, 1);
    cnt = 0;
    cyc();
    for (int k = 0; k < 6; k++) begin mid(); if (ram_en) cnt++; cyc(); end
    check("ovr_no_extra_access", cnt, 0);
    check("ovr_sticky", spi_overrun, 1);
    do_reset("ovr_reset");

    // Reset during the LP_ACC of a read abandons the response.
    lp_req = 1'b1; lp_we = 1'b0; lp_addr = 8'h30; lp_wdata = 8'h00;
    any = 1'b0; cnt = 0;
    while (!any && cnt < 8) begin
      mid();
      if (lp_gnt) any = 1'b1; else begin cyc(); cnt++; end
    end
    check("rst_mid_gnt", any, 1);
    rst_n = 1'b0; lp_req = 1'b0;
    cyc(); mid();
    check("rst_mid_outs_zero", all_outs(), 64'd0);
    cyc();
    rst_n = 1'b1;
    m_wr = 8'h00; m_rd = 8'h00; m_last_spi = 1'b0;
    any = 1'b0;
    for (int k = 0; k < 6; k++) begin mid(); any |= lp_rvalid; cyc(); end
    check("rst_mid_no_rvalid", any, 0);

`ifdef SPI_ARB_AUTOINC_EN
    spi_word(10'h0FF); void'(model_spi(10'h0FF));
    spi_word(10'h111); ea = model_spi(10'h111);
    expect_access("inc_wr1", 1'b1, 8'hFF, 8'h11, lat);
    idle(2);
    spi_word(10'h122); ea = model_spi(10'h122);
    expect_access("inc_wr2", 1'b1, 8'h00, 8'h22, lat);
    m_last_spi = 1'b1;
    idle(2);
`endif

    // Randomized sequential traffic against the reference memory image.
    for (int n = 0; n < 24; n++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          spi_word({2'b00, a}); void'(model_spi({2'b00, a}));
          spi_word({2'b01, d}); ea = model_spi({2'b01, d});
          expect_access("rnd_spi_wr", 1'b1, ea, d, lat);
          m_last_spi = 1'b1;
        end
        1: begin
          spi_word({2'b10, a}); void'(model_spi({2'b10, a}));
          spi_word({2'b11, d}); ea = model_spi({2'b11, d});
          wait_tx("rnd_spi_rd", lat, got);
          check("rnd_spi_rd_latency", lat, 4);
          check("rnd_spi_rd_data", got, exp_mem[ea]);
          m_last_spi = 1'b1;
        end
        2: lp_access("rnd_lp_wr", 1'b1, a, d);
        default: lp_access("rnd_lp_rd", 1'b0, a, d);
      endcase
      idle(2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
